// File: rtl/bcd_converter_if.sv
// Bundles the converter's request/result signals between the binary source and the display-side converter.
interface bcd_converter_if #(
    parameter int IN_WIDTH = 14
);
    logic [IN_WIDTH-1:0] value;
    logic                start;
    logic                auto_en;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [15:0]         bcd;

    modport master (
        output value, start, auto_en,
        input  busy, done, overflow, bcd
    );

    modport slave (
        input  value, start, auto_en,
        output busy, done, overflow, bcd
    );
endinterface

// File: rtl/bcd_converter.sv
// Serial double-dabble binary-to-BCD converter feeding the 4-digit display, saturating at 9999.
// state   | meaning
// IDLE    | waiting for start, a queued refresh, or a refresh tick
// CONVERT | add-3 then shift, one input bit per cycle
// FINISH  | publish digits and overflow, pulse done
module bcd_converter #(
    parameter int IN_WIDTH    = 14,
    parameter int REFRESH_DIV = 50000
) (
    input logic            clock,
    input logic            reset_n,
    bcd_converter_if.slave bus
);
    localparam int SR_W  = 16 + IN_WIDTH;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0]    LAST_BIT  = CNT_W'(IN_WIDTH - 1);
    localparam logic [15:0]         LAST_TICK = 16'(REFRESH_DIV - 1);
    localparam logic [IN_WIDTH-1:0] SAT_VAL   = IN_WIDTH'(9999);

    typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

    state_t          state;
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_adj;
    logic [CNT_W-1:0] bit_cnt;
    logic [15:0]     refresh_cnt;
    logic            pending;
    logic            ovf_cap;
    logic            tick;
    logic            trig;
    logic            over_max;
    logic            busy_r;
    logic            done_r;
    logic            overflow_r;
    logic [15:0]     bcd_r;

    assign tick     = bus.auto_en && (refresh_cnt == LAST_TICK);
    assign trig     = bus.start | pending | tick;
    assign over_max = 32'(bus.value) > 32'd9999;

    // All four digit fields are corrected in parallel before each shift.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 4; i++) begin
            if (sr[IN_WIDTH + 4*i +: 4] >= 4'd5) begin
                sr_adj[IN_WIDTH + 4*i +: 4] = sr[IN_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            sr          <= '0;
            bit_cnt     <= '0;
            refresh_cnt <= '0;
            pending     <= 1'b0;
            ovf_cap     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            overflow_r  <= 1'b0;
            bcd_r       <= 16'h0000;
        end else begin
            done_r <= 1'b0;

            if (!bus.auto_en || tick) begin
                refresh_cnt <= '0;
            end else begin
                refresh_cnt <= refresh_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (trig) begin
                        sr      <= {16'h0000, (over_max ? SAT_VAL : bus.value)};
                        ovf_cap <= over_max;
                        bit_cnt <= '0;
                        busy_r  <= 1'b1;
                        pending <= 1'b0;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    sr      <= {sr_adj[SR_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (tick) pending <= 1'b1;
                    if (bit_cnt == LAST_BIT) state <= FINISH;
                end
                FINISH: begin
                    bcd_r      <= sr[SR_W-1 -: 16];
                    overflow_r <= ovf_cap;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    if (tick) pending <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A refresh queued while busy is dropped once auto refresh is disabled.
            if (!bus.auto_en) pending <= 1'b0;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = overflow_r;
    assign bus.bcd      = bcd_r;
endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: directed vectors, latency, refresh timer and reset abort.
module tb_bcd_converter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   n_done = 0;
    int   last_done_cyc = 0;
    int   start_cyc = 0;
    logic [16:0] exp_q[$];

    bcd_converter_if #(.IN_WIDTH(14)) bus ();

    bcd_converter #(.IN_WIDTH(14), .REFRESH_DIV(20)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clock) begin
        if (bus.done === 1'b1) begin
            logic [16:0] e;
            n_done++;
            last_done_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got bcd=%h ovf=%b, required no done", bus.bcd, bus.overflow);
            end else begin
                e = exp_q.pop_front();
                if (bus.bcd !== e[15:0] || bus.overflow !== e[16]) begin
                    fails++;
                    $display("FAIL result: got bcd=%h ovf=%b, required bcd=%h ovf=%b",
                             bus.bcd, bus.overflow, e[15:0], e[16]);
                end
            end
        end
    end

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", nm, got, got, want, want);
        end
    endtask

    task automatic expect_result(input logic [15:0] b, input logic o);
        exp_q.push_back({o, b});
    endtask

    task automatic pulse_start(input int v);
        @(negedge clock);
        bus.value = 14'(v);
        bus.start = 1'b1;
        @(negedge clock);
        start_cyc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget, input string nm);
        int i = 0;
        while (n_done <= n0 && i < budget) begin
            @(posedge clock);
            i++;
        end
        checks++;
        if (n_done <= n0) begin
            fails++;
            $display("FAIL %s_timeout: got no done in %0d cycles, required a done pulse", nm, budget);
        end
    endtask

    typedef struct {int v; logic [15:0] b; logic o;} vec_t;

    initial begin
        vec_t vecs[6];
        int n0;
        int d0;
        vecs[0] = '{0,     16'h0000, 1'b0};
        vecs[1] = '{9,     16'h0009, 1'b0};
        vecs[2] = '{10,    16'h0010, 1'b0};
        vecs[3] = '{9999,  16'h9999, 1'b0};
        vecs[4] = '{10000, 16'h9999, 1'b1};
        vecs[5] = '{16383, 16'h9999, 1'b1};

        bus.value = '0;
        bus.start = 1'b0;
        bus.auto_en = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_state", {bus.busy, bus.done, bus.overflow, bus.bcd}, 0);
        end

        // 1234 with latency and busy window.
        n0 = n_done;
        expect_result(16'h1234, 1'b0);
        pulse_start(1234);
        check("busy_k", bus.busy, 1);
        for (int i = 1; i < 15; i++) begin
            @(negedge clock);
            check("busy_window", bus.busy, 1);
        end
        @(negedge clock);
        check("busy_low_at_done", bus.busy, 0);
        wait_done(n0, 30, "v1234");
        check("latency", last_done_cyc - start_cyc, 15);

        foreach (vecs[j]) begin
            n0 = n_done;
            expect_result(vecs[j].b, vecs[j].o);
            pulse_start(vecs[j].v);
            wait_done(n0, 30, "vector");
        end

        // Start during conversion is ignored; value change after capture has no effect.
        n0 = n_done;
        expect_result(16'h4321, 1'b0);
        pulse_start(4321);
        bus.value = 14'd55;
        repeat (4) @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(n0, 30, "v4321");
        repeat (40) @(posedge clock);
        check("single_done_4321", n_done - n0, 1);

        // Auto refresh every 20 cycles.
        @(negedge clock);
        bus.value = 14'd777;
        n0 = n_done;
        expect_result(16'h0777, 1'b0);
        bus.auto_en = 1'b1;
        wait_done(n0, 60, "auto1");
        d0 = last_done_cyc;
        n0 = n_done;
        expect_result(16'h0777, 1'b0);
        wait_done(n0, 60, "auto2");
        check("refresh_period", last_done_cyc - d0, 20);
        d0 = last_done_cyc;

        // Start coincident with the tick cycle.
        n0 = n_done;
        expect_result(16'h0777, 1'b0);
        do @(negedge clock); while (cyc < d0 + 4);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(n0, 60, "auto_start");
        check("tick_start_period", last_done_cyc - d0, 20);
        d0 = last_done_cyc;
        n0 = n_done;
        expect_result(16'h0777, 1'b0);
        wait_done(n0, 60, "auto4");
        check("refresh_period_after", last_done_cyc - d0, 20);

        @(negedge clock);
        bus.auto_en = 1'b0;
        n0 = n_done;
        repeat (60) @(posedge clock);
        check("no_done_auto_off", n_done - n0, 0);

        // Reset in the middle of a conversion.
        n0 = n_done;
        pulse_start(5000);
        repeat (6) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("reset_busy", bus.busy, 0);
        check("reset_bcd", bus.bcd, 0);
        check("reset_done", bus.done, 0);
        reset_n = 1'b1;
        repeat (30) @(posedge clock);
        check("no_done_after_abort", n_done - n0, 0);

        n0 = n_done;
        expect_result(16'h5000, 1'b0);
        pulse_start(5000);
        wait_done(n0, 30, "v5000");

        repeat (5) @(posedge clock);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
